// File: rtl/quat_pkg.sv
// Shared types and the Hamilton-product step schedule for the sequential quaternion multiplier.
package quat_pkg;

  localparam int QW  = 16;
  localparam int QRW = 2 * QW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  // sel encoding: a=0, b=1, c=2, d=3; sub=1 subtracts the product
  typedef struct packed {
    logic       sub;
    logic [1:0] sel_x;
    logic [1:0] sel_y;
  } step_t;

  // Steps 4k..4k+3 accumulate result component k (scalar, i, j, k)
  function automatic step_t step_rom(input logic [3:0] s);
    step_t e;
    case (s)
      4'd0:    e = '{1'b0, 2'd0, 2'd0};
      4'd1:    e = '{1'b1, 2'd1, 2'd1};
      4'd2:    e = '{1'b1, 2'd2, 2'd2};
      4'd3:    e = '{1'b1, 2'd3, 2'd3};
      4'd4:    e = '{1'b0, 2'd0, 2'd1};
      4'd5:    e = '{1'b0, 2'd1, 2'd0};
      4'd6:    e = '{1'b0, 2'd2, 2'd3};
      4'd7:    e = '{1'b1, 2'd3, 2'd2};
      4'd8:    e = '{1'b0, 2'd0, 2'd2};
      4'd9:    e = '{1'b1, 2'd1, 2'd3};
      4'd10:   e = '{1'b0, 2'd2, 2'd0};
      4'd11:   e = '{1'b0, 2'd3, 2'd1};
      4'd12:   e = '{1'b0, 2'd0, 2'd3};
      4'd13:   e = '{1'b0, 2'd1, 2'd2};
      4'd14:   e = '{1'b1, 2'd2, 2'd1};
      default: e = '{1'b0, 2'd3, 2'd0};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/quat_mac.sv
// Shared signed W x W multiplier feeding one of four RW+2 accumulators.
// res_o is the post-update value, wrapped to RW bits or clamped when QMUL_SAT_EN is defined.
module quat_mac #(
  parameter int W  = 16,
  parameter int RW = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_i,
  input  logic                en_i,
  input  logic                sub_i,
  input  logic [1:0]          sel_i,
  input  logic signed [W-1:0] x_i,
  input  logic signed [W-1:0] y_i,
  output logic [3:0][RW-1:0]  res_o
`ifdef QMUL_SAT_EN
  ,
  output logic [3:0]          sat_o
`endif
);

  localparam int AW = RW + 2;

  logic signed [2*W-1:0] x_ext, y_ext, prod;
  logic signed [AW-1:0]  prod_ext;
  logic signed [AW-1:0]  acc_q [4];
  logic signed [AW-1:0]  acc_d [4];

  // Widening before the multiply keeps (-2^(W-1))^2 exact
  assign x_ext    = (2*W)'(x_i);
  assign y_ext    = (2*W)'(y_i);
  assign prod     = x_ext * y_ext;
  assign prod_ext = AW'(prod);

  always_comb begin
    for (int k = 0; k < 4; k++) acc_d[k] = acc_q[k];
    if (en_i) acc_d[sel_i] = sub_i ? acc_q[sel_i] - prod_ext : acc_q[sel_i] + prod_ext;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      for (int k = 0; k < 4; k++) acc_q[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) acc_q[k] <= acc_d[k];
    end
  end

  always_comb begin
    res_o = '0;
`ifdef QMUL_SAT_EN
    sat_o = '0;
    for (int k = 0; k < 4; k++) begin
      // Out of range when the bits above the RW sign bit disagree with the true sign
      if (acc_d[k][AW-1:RW-1] != {(AW-RW+1){acc_d[k][AW-1]}}) begin
        sat_o[k] = 1'b1;
        res_o[k] = acc_d[k][AW-1] ? {1'b1, {(RW-1){1'b0}}} : {1'b0, {(RW-1){1'b1}}};
      end else begin
        res_o[k] = acc_d[k][RW-1:0];
      end
    end
`else
    for (int k = 0; k < 4; k++) res_o[k] = acc_d[k][RW-1:0];
`endif
  end

endmodule

// File: rtl/quat_mul_seq.sv
// Iterative Hamilton product Q1*Q2: one MAC per cycle over 16 steps, valid/ready on both sides.
// Optional QMUL_SAT_EN clamps results to RW bits and adds the sticky sat_flag output.
module quat_mul_seq
  import quat_pkg::*;
#(
  parameter int W  = QW,
  parameter int RW = 2 * W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [W-1:0]  a1,
  input  logic signed [W-1:0]  b1,
  input  logic signed [W-1:0]  c1,
  input  logic signed [W-1:0]  d1,
  input  logic signed [W-1:0]  a2,
  input  logic signed [W-1:0]  b2,
  input  logic signed [W-1:0]  c2,
  input  logic signed [W-1:0]  d2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [RW-1:0] r1,
  output logic signed [RW-1:0] r2,
  output logic signed [RW-1:0] r3,
  output logic signed [RW-1:0] r4,
  output logic                 busy
`ifdef QMUL_SAT_EN
  ,
  output logic                 sat_flag
`endif
);

  state_e               state_q, state_d;
  logic [3:0]           step_q;
  logic [3:0][W-1:0]    op1_q, op2_q;
  logic [3:0][RW-1:0]   r_q;
  logic [3:0][RW-1:0]   res;
  logic                 accept;
  step_t                rom;

  assign accept = in_valid & in_ready;
  assign rom    = step_rom(step_q);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = ~rst;
        if (in_valid && !rst) state_d = MAC;
      end
      MAC: begin
        busy = 1'b1;
        if (step_q == 4'd15) state_d = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step_q <= '0;
      op1_q  <= '0;
      op2_q  <= '0;
      r_q    <= '0;
    end else if (accept) begin
      step_q <= '0;
      op1_q  <= {d1, c1, b1, a1};
      op2_q  <= {d2, c2, b2, a2};
    end else if (busy) begin
      step_q <= step_q + 4'd1;
      // The last product lands in the accumulator and the result register on the same edge
      if (step_q == 4'd15) r_q <= res;
    end
  end

`ifdef QMUL_SAT_EN
  logic [3:0] sat_vec;
  logic       sat_q;

  always_ff @(posedge clk) begin
    if (rst || accept)                sat_q <= 1'b0;
    else if (busy && step_q == 4'd15) sat_q <= |sat_vec;
  end

  assign sat_flag = sat_q;
`endif

  quat_mac #(.W(W), .RW(RW)) u_mac (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (accept),
    .en_i  (busy),
    .sub_i (rom.sub),
    .sel_i (step_q[3:2]),
    .x_i   (op1_q[rom.sel_x]),
    .y_i   (op2_q[rom.sel_y]),
    .res_o (res)
`ifdef QMUL_SAT_EN
    ,
    .sat_o (sat_vec)
`endif
  );

  assign r1 = r_q[0];
  assign r2 = r_q[1];
  assign r3 = r_q[2];
  assign r4 = r_q[3];

endmodule

// File: tb/tb_quat_mul_seq.sv
// Bench for quat_mul_seq: directed table of Hamilton products, multi-cycle corner sequences,
// and random operands checked against a sum-of-products reference model.
module tb_quat_mul_seq;

  typedef struct packed { logic signed [15:0] a, b, c, d; } quat_t;
  typedef struct packed { logic signed [31:0] r1, r2, r3, r4; } res_t;
  typedef struct { quat_t p; quat_t q; res_t exp; logic sat; } vec_t;

  localparam int IMIN = 32'sh8000_0000;
  localparam int IMAX = 32'sh7fff_ffff;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic signed [15:0] a1, b1, c1, d1, a2, b2, c2, d2;
  logic signed [31:0] r1, r2, r3, r4;
`ifdef QMUL_SAT_EN
  logic sat_flag;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  quat_mul_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a1(a1), .b1(b1), .c1(c1), .d1(d1), .a2(a2), .b2(b2), .c2(c2), .d2(d2),
    .out_valid(out_valid), .out_ready(out_ready),
    .r1(r1), .r2(r2), .r3(r3), .r4(r4), .busy(busy)
`ifdef QMUL_SAT_EN
    , .sat_flag(sat_flag)
`endif
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic quat_t mkq(input int a, input int b, input int c, input int d);
    quat_t x;
    x.a = 16'(a); x.b = 16'(b); x.c = 16'(c); x.d = 16'(d);
    return x;
  endfunction

  function automatic res_t mkr(input int a, input int b, input int c, input int d);
    res_t x;
    x.r1 = a; x.r2 = b; x.r3 = c; x.r4 = d;
    return x;
  endfunction

  function automatic logic [15:0] rnd_comp();
    case ($urandom_range(0, 5))
      0:       return 16'h8000;
      1:       return 16'h7fff;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic quat_t rnd_quat();
    quat_t x;
    x.a = rnd_comp(); x.b = rnd_comp(); x.c = rnd_comp(); x.d = rnd_comp();
    return x;
  endfunction

  // Reference: exact Hamilton product in 64-bit integers, then reduced to 32 bits
  function automatic res_t model(input quat_t p, input quat_t q, output logic sat);
    longint pa, pb, pc, pd, qa, qb, qc, qd;
    longint s [4];
    res_t r;
    pa = p.a; pb = p.b; pc = p.c; pd = p.d;
    qa = q.a; qb = q.b; qc = q.c; qd = q.d;
    s[0] = pa*qa - pb*qb - pc*qc - pd*qd;
    s[1] = pa*qb + pb*qa + pc*qd - pd*qc;
    s[2] = pa*qc - pb*qd + pc*qa + pd*qb;
    s[3] = pa*qd + pb*qc - pc*qb + pd*qa;
    sat = 1'b0;
`ifdef QMUL_SAT_EN
    for (int k = 0; k < 4; k++) begin
      if (s[k] > longint'(IMAX)) begin s[k] = longint'(IMAX); sat = 1'b1; end
      else if (s[k] < longint'(IMIN)) begin s[k] = longint'(IMIN); sat = 1'b1; end
    end
`endif
    r.r1 = 32'(s[0]); r.r2 = 32'(s[1]); r.r3 = 32'(s[2]); r.r4 = 32'(s[3]);
    return r;
  endfunction

  task automatic drive(input quat_t p, input quat_t q);
    a1 = p.a; b1 = p.b; c1 = p.c; d1 = p.d;
    a2 = q.a; b2 = q.b; c2 = q.c; d2 = q.d;
  endtask

  // Presents operands, waits for acceptance, then scrambles the inputs; returns at the first negedge after accept
  task automatic start_op(input string tag, input quat_t p, input quat_t q);
    int n;
    @(negedge clk);
    drive(p, q);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    chk({tag, "_accept"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    drive(rnd_quat(), rnd_quat());
    chk({tag, "_busy"}, busy, 1);
`ifdef QMUL_SAT_EN
    chk({tag, "_sat_cleared"}, sat_flag, 0);
`endif
  endtask

  // Waits for out_valid from the first negedge after accept; checks latency, results and the handshake
  task automatic wait_res(input string tag, input res_t exp, input logic exp_sat);
    int lat;
    lat = 0;
    while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
    chk({tag, "_latency"}, lat, 16);
    chk({tag, "_r1"}, r1, exp.r1);
    chk({tag, "_r2"}, r2, exp.r2);
    chk({tag, "_r3"}, r3, exp.r3);
    chk({tag, "_r4"}, r4, exp.r4);
`ifdef QMUL_SAT_EN
    chk({tag, "_sat"}, sat_flag, exp_sat);
`else
    if (exp_sat) chk({tag, "_no_sat_expected"}, exp_sat, 0);
`endif
    if (out_ready) begin
      @(negedge clk);
      chk({tag, "_hs_out_valid"}, out_valid, 0);
      chk({tag, "_hs_in_ready"}, in_ready, 1);
    end
  endtask

  vec_t  tbl [8];
  quat_t p, q, p2, q2;
  res_t  e;
  logic  es;
  int    bad;

  initial begin
    tbl[0] = '{mkq(0,0,0,0),      mkq(0,0,0,0),     mkr(0,0,0,0),       1'b0};
    tbl[1] = '{mkq(1,0,0,0),      mkq(1,0,0,0),     mkr(1,0,0,0),       1'b0};
    tbl[2] = '{mkq(0,1,0,0),      mkq(0,1,0,0),     mkr(-1,0,0,0),      1'b0};
    tbl[3] = '{mkq(2,3,-4,1),     mkq(1,0,0,0),     mkr(2,3,-4,1),      1'b0};
    tbl[4] = '{mkq(-5,2,1,-3),    mkq(4,-2,2,1),    mkr(-15,25,-2,-11), 1'b0};
    tbl[5] = '{mkq(7,-3,8,2),     mkq(-4,6,-5,3),   mkr(24,88,-46,-20), 1'b0};
`ifdef QMUL_SAT_EN
    tbl[6] = '{mkq(-32768,-32768,-32768,-32768), mkq(-32768,-32768,-32768,-32768),
               mkr(IMIN,IMAX,IMAX,IMAX), 1'b1};
    tbl[7] = '{mkq(32767,32767,32767,32767), mkq(32767,-32767,-32767,-32767),
               mkr(IMAX,0,0,0), 1'b1};
`else
    tbl[6] = '{mkq(-32768,-32768,-32768,-32768), mkq(-32768,-32768,-32768,-32768),
               mkr(IMIN,IMIN,IMIN,IMIN), 1'b0};
    tbl[7] = '{mkq(32767,32767,32767,32767), mkq(32767,-32767,-32767,-32767),
               mkr(-262140,0,0,0), 1'b0};
`endif

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    drive(mkq(0,0,0,0), mkq(0,0,0,0));
    @(negedge clk);
    @(negedge clk);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_r", {r1, r2, r3, r4} == '0, 1);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", in_ready, 1);

    for (int i = 0; i < 8; i++) begin
      start_op($sformatf("row%0d", i), tbl[i].p, tbl[i].q);
      wait_res($sformatf("row%0d", i), tbl[i].exp, tbl[i].sat);
    end

    // Backpressure: result held and input refused while out_ready is low
    out_ready = 1'b0;
    p = mkq(7,-3,8,2); q = mkq(-4,6,-5,3);
    start_op("bp", p, q);
    wait_res("bp", mkr(24,88,-46,-20), 1'b0);
    p2 = rnd_quat(); q2 = rnd_quat();
    drive(p2, q2);
    in_valid = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!out_valid || in_ready || busy || r1 != 24 || r2 != 88 || r3 != -46 || r4 != -20) bad++;
    end
    chk("bp_hold_violations", bad, 0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_out_valid", out_valid, 0);
    chk("bp_release_in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_next_accepted", busy, 1);
    e = model(p2, q2, es);
    wait_res("bp_next", e, es);

    // Reset in the middle of MAC discards the partial product
    start_op("abort", mkq(7,-3,8,2), mkq(-4,6,-5,3));
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_r", {r1, r2, r3, r4} == '0, 1);
    rst = 1'b0;
    bad = 0;
    repeat (20) begin @(negedge clk); if (out_valid) bad++; end
    chk("abort_no_out_valid", bad, 0);
    chk("abort_r_after", {r1, r2, r3, r4} == '0, 1);
    start_op("post_abort", mkq(-5,2,1,-3), mkq(4,-2,2,1));
    wait_res("post_abort", mkr(-15,25,-2,-11), 1'b0);

    for (int i = 0; i < 24; i++) begin
      p = rnd_quat(); q = rnd_quat();
      e = model(p, q, es);
      start_op($sformatf("rnd%0d", i), p, q);
      wait_res($sformatf("rnd%0d", i), e, es);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
